// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver. It captures one byte per rising valid level
// and gives the consumer first-word-fall-through reads. It also drives CTS with hysteresis.
module uart_rx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int ALMOST_FULL  = 12,
  parameter int CTS_HYST     = 4,
  parameter int DROP_ON_PERR = 1
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic [DATA_WIDTH-1:0]      iData_rx,
  input  logic                       iData_valid,
  input  logic                       iPar_err,
  input  logic                       iRd_en,
  input  logic                       iClr_err,
  output logic [DATA_WIDTH-1:0]      oData,
  output logic                       oEmpty,
  output logic                       oFull,
  output logic [$clog2(DEPTH):0]     oCount,
  output logic                       oCTS,
  output logic                       oOverflow,
  output logic [7:0]                 oErr_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL);
  localparam logic [CW-1:0] REL_CNT  = CW'(ALMOST_FULL - CTS_HYST);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic          DROP_EN  = (DROP_ON_PERR != 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          cts_q, cts_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    errCnt_q, errCnt_d;
  logic          valid_q, perr_q;

  logic wrEvt, errEvt, wrReq, wrAcc, rdAcc, isFull, isEmpty;

  assign isFull  = (count_q == FULL_CNT);
  assign isEmpty = (count_q == '0);

  always_comb begin
    wrEvt      = iData_valid & ~valid_q;
    errEvt     = iPar_err & ~perr_q;
    wrReq      = wrEvt & ~(errEvt & DROP_EN);
    rdAcc      = iRd_en & ~isEmpty;
    // A pop on a full FIFO frees the slot the incoming byte lands in.
    wrAcc      = wrReq & (~isFull | rdAcc);
    wrPtr_d    = wrAcc ? wrPtr_q + PTR_ONE : wrPtr_q;
    rdPtr_d    = rdAcc ? rdPtr_q + PTR_ONE : rdPtr_q;
    count_d    = count_q + CW'(wrAcc) - CW'(rdAcc);
    overflow_d = overflow_q | (wrReq & isFull & ~rdAcc);
    errCnt_d   = errCnt_q;
    if (errEvt && errCnt_q != 8'hFF) begin
      errCnt_d = errCnt_q + 8'd1;
    end
    if (iClr_err) begin
      errCnt_d   = 8'd0;
      overflow_d = 1'b0;
    end
    cts_d = cts_q;
    if (count_q >= AF_CNT) begin
      cts_d = 1'b1;
    end else if (count_q <= REL_CNT) begin
      cts_d = 1'b0;
    end
  end

  // Edge detectors reset high so a level still asserted at reset release is not captured.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      cts_q      <= 1'b0;
      overflow_q <= 1'b0;
      errCnt_q   <= 8'd0;
      valid_q    <= 1'b1;
      perr_q     <= 1'b1;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      cts_q      <= cts_d;
      overflow_q <= overflow_d;
      errCnt_q   <= errCnt_d;
      valid_q    <= iData_valid;
      perr_q     <= iPar_err;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst && wrAcc) begin
      mem[wrPtr_q] <= iData_rx;
    end
  end

  assign oData     = mem[rdPtr_q];
  assign oEmpty    = isEmpty;
  assign oFull     = isFull;
  assign oCount    = count_q;
  assign oCTS      = cts_q;
  assign oOverflow = overflow_q;
  assign oErr_cnt  = errCnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and random checks of uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int REL   = 8;

  logic       iClk = 1'b0;
  logic       iRst;
  logic [7:0] iData_rx;
  logic       iData_valid;
  logic       iPar_err;
  logic       iRd_en;
  logic       iClr_err;
  logic [7:0] oData;
  logic       oEmpty;
  logic       oFull;
  logic [4:0] oCount;
  logic       oCTS;
  logic       oOverflow;
  logic [7:0] oErr_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: a byte queue plus the sticky/hysteresis state.
  logic [7:0] modelQ[$];
  bit         mOverflow;
  bit         mCts;
  bit         mPrevValid;
  bit         mPrevPerr;
  int         mErrCnt;

  uart_rx_fifo dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iData_rx    (iData_rx),
    .iData_valid (iData_valid),
    .iPar_err    (iPar_err),
    .iRd_en      (iRd_en),
    .iClr_err    (iClr_err),
    .oData       (oData),
    .oEmpty      (oEmpty),
    .oFull       (oFull),
    .oCount      (oCount),
    .oCTS        (oCTS),
    .oOverflow   (oOverflow),
    .oErr_cnt    (oErr_cnt)
  );

  always #5 iClk = ~iClk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".count"}, 32'(oCount), 32'(modelQ.size()));
    checkVal({tag, ".empty"}, 32'(oEmpty), 32'(modelQ.size() == 0));
    checkVal({tag, ".full"}, 32'(oFull), 32'(modelQ.size() == DEPTH));
    checkVal({tag, ".cts"}, 32'(oCTS), 32'(mCts));
    checkVal({tag, ".ovf"}, 32'(oOverflow), 32'(mOverflow));
    checkVal({tag, ".errcnt"}, 32'(oErr_cnt), 32'(mErrCnt));
    if (modelQ.size() > 0) checkVal({tag, ".data"}, 32'(oData), 32'(modelQ[0]));
  endtask

  // Advance one clock; the model consumes the inputs the DUT saw at that edge.
  task automatic applyStimulus();
    bit         v  = iData_valid;
    bit         p  = iPar_err;
    bit         r  = iRd_en;
    bit         c  = iClr_err;
    bit         rs = iRst;
    logic [7:0] d  = iData_rx;
    int         oldSize;
    bit         wr, er, rdOk;
    @(posedge iClk);
    #1;
    if (rs) begin
      modelQ.delete();
      mOverflow  = 0;
      mCts       = 0;
      mErrCnt    = 0;
      mPrevValid = 1;
      mPrevPerr  = 1;
      return;
    end
    oldSize = modelQ.size();
    wr      = v && !mPrevValid;
    er      = p && !mPrevPerr;
    rdOk    = r && (oldSize > 0);
    if (oldSize >= AF) mCts = 1;
    else if (oldSize <= REL) mCts = 0;
    if (rdOk) void'(modelQ.pop_front());
    if (wr && !er) begin
      if (oldSize < DEPTH || rdOk) modelQ.push_back(d);
      else mOverflow = 1;
    end
    if (er && mErrCnt < 255) mErrCnt++;
    if (c) begin
      mErrCnt   = 0;
      mOverflow = 0;
    end
    mPrevValid = v;
    mPrevPerr  = p;
  endtask

  task automatic sendFrame(input logic [7:0] d);
    iData_valid = 1'b0;
    applyStimulus();
    iData_rx    = d;
    iData_valid = 1'b1;
    applyStimulus();
    checkOutput("frame");
  endtask

  initial begin
    iRst = 1'b1; iData_rx = 8'h00; iData_valid = 1'b1; iPar_err = 1'b0;
    iRd_en = 1'b0; iClr_err = 1'b0;

    // Valid held through reset release must not be captured.
    applyStimulus();
    applyStimulus();
    checkOutput("reset");
    iRst = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("release");
    checkVal("release.emptyConst", 32'(oEmpty), 32'd1);
    sendFrame(8'h41);
    checkVal("first.dataConst", 32'(oData), 32'h41);
    iRd_en = 1'b1; applyStimulus(); iRd_en = 1'b0;
    checkOutput("pop41");

    // A long valid level yields exactly one entry.
    sendFrame(8'h5A);
    repeat (99) applyStimulus();
    checkOutput("hold");
    checkVal("hold.countConst", 32'(oCount), 32'd1);
    iRd_en = 1'b1; applyStimulus(); iRd_en = 1'b0;
    checkOutput("popHold");
    checkVal("popHold.emptyConst", 32'(oEmpty), 32'd1);

    // Fill to full, then overflow.
    for (int i = 0; i < 16; i++) begin
      sendFrame(8'(i));
    end
    applyStimulus();
    checkOutput("full");
    checkVal("full.ctsConst", 32'(oCTS), 32'd1);
    checkVal("full.fullConst", 32'(oFull), 32'd1);
    sendFrame(8'hFF);
    checkVal("ovf.const", 32'(oOverflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      checkVal("popSeq.data", 32'(oData), 32'(i));
      iRd_en = 1'b1; applyStimulus(); iRd_en = 1'b0;
      checkOutput("popSeq");
    end
    applyStimulus();
    checkOutput("ctsRelease");
    checkVal("ctsRelease.const", 32'(oCTS), 32'd0);

    // Refill to full, clear overflow, then write+read together while full.
    for (int i = 0; i < 8; i++) sendFrame(8'(8'h10 + i));
    iClr_err = 1'b1; applyStimulus(); iClr_err = 1'b0;
    checkOutput("clrOvf");
    iData_valid = 1'b0; applyStimulus();
    iData_rx = 8'hAB; iData_valid = 1'b1; iRd_en = 1'b1;
    applyStimulus();
    iRd_en = 1'b0;
    checkOutput("fullRw");
    checkVal("fullRw.countConst", 32'(oCount), 32'd16);
    checkVal("fullRw.ovfConst", 32'(oOverflow), 32'd0);
    iRd_en = 1'b1;
    repeat (16) begin
      applyStimulus();
      checkOutput("drain");
    end
    iRd_en = 1'b0;

    // Parity-error frames alone bump the error count only.
    repeat (3) begin
      iPar_err = 1'b0; applyStimulus();
      iPar_err = 1'b1; applyStimulus();
    end
    checkOutput("perr");
    checkVal("perr.const", 32'(oErr_cnt), 32'd3);
    iClr_err = 1'b1; applyStimulus(); iClr_err = 1'b0;
    checkOutput("clrErr");

    // Saturation of the error counter.
    repeat (260) begin
      iPar_err = 1'b0; applyStimulus();
      iPar_err = 1'b1; applyStimulus();
    end
    checkOutput("errSat");
    checkVal("errSat.const", 32'(oErr_cnt), 32'd255);
    iPar_err = 1'b0;

    // Reset mid-fill discards everything.
    for (int i = 0; i < 5; i++) sendFrame(8'(8'hC0 + i));
    iRst = 1'b1; applyStimulus(); iRst = 1'b0;
    checkOutput("midReset");
    checkVal("midReset.countConst", 32'(oCount), 32'd0);

    // Randomized traffic with occasional clears and resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 2) == 0) iData_valid = ~iData_valid;
      iData_rx = 8'($urandom);
      iPar_err = ($urandom_range(0, 9) == 0);
      iRd_en   = (cyc < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      iClr_err = ($urandom_range(0, 59) == 0);
      iRst     = ($urandom_range(0, 699) == 0);
      applyStimulus();
      checkOutput("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
